// File: rtl/uart_tx_buffered_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_buffered_pkg
//  Purpose  : Shared UART definitions: TX FSM state encoding, default baud
//             divisor and the memory-mapped UART TX register address that
//             the memory-access stage decodes.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_tx_buffered_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

   // 100 MHz core clock, 115200 baud
   localparam int DEFAULT_CLKS_PER_BIT = 868;

   // Store address of the UART TX data register, shared with memory_access
   localparam logic [31:0] UART_TX_ADDR = 32'h1000_0000;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock show-ahead FIFO. Writes while full and reads while
//             empty are ignored; a full FIFO never accepts a write even if a
//             read happens on the same edge.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int                c_ADDR_W    = $clog2(DEPTH);
   localparam logic [c_ADDR_W:0] c_DEPTH_CNT = (c_ADDR_W+1)'(DEPTH);
   localparam logic [c_ADDR_W:0] c_CNT_ONE   = (c_ADDR_W+1)'(1);
   localparam logic [c_ADDR_W-1:0] c_PTR_ONE = c_ADDR_W'(1);

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [c_ADDR_W-1:0] r_wr_ptr;
   logic [c_ADDR_W-1:0] r_rd_ptr;
   logic [c_ADDR_W:0]   r_count;
   logic                w_push_ok;
   logic                w_pop_ok;

   assign full      = (r_count == c_DEPTH_CNT);
   assign empty     = (r_count == '0);
   assign w_push_ok = push & ~full;
   assign w_pop_ok  = pop & ~empty;
   assign dout      = r_mem[r_rd_ptr];
   assign count     = r_count;

   // Storage array: written on accepted pushes only, no reset needed
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally (power-of-two depth); count tracks occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         if (w_push_ok && !w_pop_ok) begin
            r_count <= r_count + c_CNT_ONE;
         end else if (!w_push_ok && w_pop_ok) begin
            r_count <= r_count - c_CNT_ONE;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_buffered
//  Purpose  : FIFO-buffered 8N1 UART transmitter fed by the memory-access
//             stage. Stores never stall; bytes are serialised LSB first and
//             frames run back to back while the FIFO holds data.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
   import uart_tx_buffered_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 8,
   parameter int DATA_BITS    = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int                c_CNT_W     = $clog2(CLKS_PER_BIT);
   localparam int                c_BIT_W     = $clog2(DATA_BITS);
   localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [c_CNT_W-1:0] c_BAUD_ONE  = c_CNT_W'(1);
   localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);
   localparam logic [c_BIT_W-1:0] c_BIT_ONE   = c_BIT_W'(1);

   uart_state_t          r_state, w_next_state;
   logic [DATA_BITS-1:0] r_shift, w_next_shift;
   logic [c_CNT_W-1:0]   r_baud, w_next_baud;
   logic [c_BIT_W-1:0]   r_bit, w_next_bit;
   logic                 r_tx, w_next_tx;
   logic                 r_busy, w_next_busy;
   logic                 r_overflow;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_baud_done;
   logic [DATA_BITS-1:0] w_head;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_valid),
      .pop   (w_pop),
      .din   (tx_data),
      .dout  (w_head),
      .count (fifo_count),
      .full  (w_full),
      .empty (w_empty)
   );

   assign tx_ready    = ~w_full;
   assign tx          = r_tx;
   assign busy        = r_busy;
   assign overflow    = r_overflow;
   assign w_baud_done = (r_baud == c_BAUD_LAST);

   // Sticky flag for any write that arrived while the FIFO was full
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow <= 1'b0;
      end else if (tx_valid && w_full) begin
         r_overflow <= 1'b1;
      end
   end

   // FSM state, shifter, baud/bit counters and registered line outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_baud  <= '0;
         r_bit   <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_shift <= w_next_shift;
         r_baud  <= w_next_baud;
         r_bit   <= w_next_bit;
         r_tx    <= w_next_tx;
         r_busy  <= w_next_busy;
      end
   end

   // Next-state logic; tx/busy are computed for the state being entered so
   // the line changes on the same edge as the state register
   always_comb begin
      w_next_state = r_state;
      w_next_shift = r_shift;
      w_next_baud  = r_baud;
      w_next_bit   = r_bit;
      w_next_tx    = r_tx;
      w_next_busy  = r_busy;
      w_pop        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_next_tx   = 1'b1;
            w_next_busy = 1'b0;
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_next_shift = w_head;
               w_next_baud  = '0;
               w_next_bit   = '0;
               w_next_state = ST_START;
               w_next_tx    = 1'b0;
               w_next_busy  = 1'b1;
            end
         end
         ST_START: begin
            if (w_baud_done) begin
               w_next_baud  = '0;
               w_next_state = ST_DATA;
               w_next_tx    = r_shift[0];
            end else begin
               w_next_baud  = r_baud + c_BAUD_ONE;
            end
         end
         ST_DATA: begin
            if (w_baud_done) begin
               w_next_baud = '0;
               if (r_bit == c_BIT_LAST) begin
                  w_next_state = ST_STOP;
                  w_next_tx    = 1'b1;
               end else begin
                  w_next_bit   = r_bit + c_BIT_ONE;
                  w_next_shift = {1'b0, r_shift[DATA_BITS-1:1]};
                  w_next_tx    = r_shift[1];
               end
            end else begin
               w_next_baud = r_baud + c_BAUD_ONE;
            end
         end
         ST_STOP: begin
            if (w_baud_done) begin
               w_next_baud = '0;
               if (!w_empty) begin
                  // Chain straight into the next frame, no idle gap
                  w_pop        = 1'b1;
                  w_next_shift = w_head;
                  w_next_bit   = '0;
                  w_next_state = ST_START;
                  w_next_tx    = 1'b0;
               end else begin
                  w_next_state = ST_IDLE;
                  w_next_tx    = 1'b1;
                  w_next_busy  = 1'b0;
               end
            end else begin
               w_next_baud = r_baud + c_BAUD_ONE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_next_tx    = 1'b1;
            w_next_busy  = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_buffered
//  Purpose  : Directed self-checking bench for uart_tx_buffered with
//             CLKS_PER_BIT=4 and FIFO_DEPTH=8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

   localparam int c_CPB   = 4;
   localparam int c_DEPTH = 8;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx;
   logic       busy;
   logic [3:0] fifo_count;
   logic       overflow;

   int errors;
   int checks;

   uart_tx_buffered #(
      .CLKS_PER_BIT (c_CPB),
      .FIFO_DEPTH   (c_DEPTH),
      .DATA_BITS    (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hold reset for a few cycles, release on a falling edge
   task automatic do_reset();
      rst      = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Line receiver: waits for a start bit, samples each bit mid-period
   task automatic rx_byte(output logic [7:0] b);
      int n;
      b = 8'h00;
      n = 0;
      while (tx !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL rx_start_timeout: tx=%b, required 0 within 2000 cycles", tx);
         return;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL rx_start_mid: tx=%b, required 0", tx);
      end
      for (int i = 0; i < 8; i++) begin
         repeat (4) @(negedge clk);
         b[i] = tx;
      end
      repeat (4) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL rx_stop_bit: tx=%b, required 1", tx);
      end
   endtask

   task automatic test_reset();
      rst      = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      checks += 5;
      if (tx !== 1'b1)         begin errors++; $display("FAIL rst_tx: got %b, required 1", tx); end
      if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
      if (tx_ready !== 1'b1)   begin errors++; $display("FAIL rst_ready: got %b, required 1", tx_ready); end
      if (fifo_count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d, required 0", fifo_count); end
      if (overflow !== 1'b0)   begin errors++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
      rst = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         checks++;
         if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_line cycle %0d: tx=%b busy=%b, required tx=1 busy=0", i, tx, busy);
         end
      end
   endtask

   task automatic test_single();
      logic [9:0] frame;
      frame = {1'b1, 8'hA5, 1'b0};
      tx_data  = 8'hA5;
      tx_valid = 1'b1;
      @(negedge clk);            // edge E has passed
      tx_valid = 1'b0;
      checks++;
      if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_count_E: got %0d, required 1", fifo_count); end
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);         // after edge E+k
         checks++;
         if (busy !== 1'b1 || tx !== frame[(k-1)/4]) begin
            errors++;
            $display("FAIL single_frame E+%0d: tx=%b busy=%b, required tx=%b busy=1", k, tx, busy, frame[(k-1)/4]);
         end
         if (k == 1) begin
            checks++;
            if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_count_E1: got %0d, required 0", fifo_count); end
         end
      end
      @(negedge clk);            // after edge E+41
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL single_end E+41: tx=%b busy=%b, required tx=1 busy=0", tx, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b0, b1;
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      @(negedge clk);            // after E
      tx_data  = 8'h0F;
      @(negedge clk);            // after E+1: pop of 0x55 and push of 0x0F
      tx_valid = 1'b0;
      checks++;
      if (fifo_count !== 4'd1) begin errors++; $display("FAIL b2b_count: got %0d, required 1", fifo_count); end
      fork
         begin
            for (int i = 0; i < 80; i++) begin
               checks++;
               if (busy !== 1'b1) begin
                  errors++;
                  $display("FAIL b2b_busy E+%0d: got %b, required 1", i + 1, busy);
               end
               @(negedge clk);
            end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b, required 0", busy); end
         end
         begin
            rx_byte(b0);
            rx_byte(b1);
         end
      join
      checks += 2;
      if (b0 !== 8'h55) begin errors++; $display("FAIL b2b_byte0: got %h, required 55", b0); end
      if (b1 !== 8'h0F) begin errors++; $display("FAIL b2b_byte1: got %h, required 0f", b1); end
   endtask

   task automatic test_overflow();
      logic [7:0] rx_q [9];
      fork
         begin
            for (int i = 1; i <= 10; i++) begin
               if (i == 10) begin
                  checks += 3;
                  if (tx_ready !== 1'b0)   begin errors++; $display("FAIL ovf_ready: got %b, required 0", tx_ready); end
                  if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count_full: got %0d, required 8", fifo_count); end
                  if (overflow !== 1'b0)   begin errors++; $display("FAIL ovf_early: got %b, required 0", overflow); end
               end
               tx_data  = 8'(i);
               tx_valid = 1'b1;
               @(negedge clk);
            end
            tx_valid = 1'b0;
            checks += 2;
            if (overflow !== 1'b1)   begin errors++; $display("FAIL ovf_set: got %b, required 1", overflow); end
            if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count_after: got %0d, required 8", fifo_count); end
         end
         begin
            for (int j = 0; j < 9; j++) begin
               rx_byte(rx_q[j]);
            end
         end
      join
      for (int j = 0; j < 9; j++) begin
         checks++;
         if (rx_q[j] !== 8'(j + 1)) begin
            errors++;
            $display("FAIL ovf_rx[%0d]: got %h, required %h", j, rx_q[j], 8'(j + 1));
         end
      end
      repeat (20) @(negedge clk);
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         tx_data  = 8'h20 + 8'(i);
         tx_valid = 1'b1;
         @(negedge clk);         // after E+i
      end
      tx_valid = 1'b0;
      repeat (32) @(negedge clk); // after E+40: STOP terminal is the next edge
      checks += 3;
      if (fifo_count !== 4'd8) begin errors++; $display("FAIL fp_count_pre: got %0d, required 8", fifo_count); end
      if (overflow !== 1'b0)   begin errors++; $display("FAIL fp_ovf_pre: got %b, required 0", overflow); end
      if (tx_ready !== 1'b0)   begin errors++; $display("FAIL fp_ready_pre: got %b, required 0", tx_ready); end
      tx_data  = 8'h99;
      tx_valid = 1'b1;
      @(negedge clk);            // after E+41
      tx_valid = 1'b0;
      checks += 5;
      if (fifo_count !== 4'd7) begin errors++; $display("FAIL fp_count_post: got %0d, required 7", fifo_count); end
      if (overflow !== 1'b1)   begin errors++; $display("FAIL fp_ovf_post: got %b, required 1", overflow); end
      if (tx_ready !== 1'b1)   begin errors++; $display("FAIL fp_ready_post: got %b, required 1", tx_ready); end
      if (busy !== 1'b1)       begin errors++; $display("FAIL fp_busy_chain: got %b, required 1", busy); end
      if (tx !== 1'b0)         begin errors++; $display("FAIL fp_next_start: got %b, required 0", tx); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      do_reset();
      tx_data  = 8'hFF;
      tx_valid = 1'b1;
      @(negedge clk);            // after E
      for (int i = 1; i <= 3; i++) begin
         tx_data = 8'h80 + 8'(i);
         @(negedge clk);         // after E+i
      end
      tx_valid = 1'b0;
      checks++;
      if (fifo_count !== 4'd3) begin errors++; $display("FAIL rm_queued: got %0d, required 3", fifo_count); end
      repeat (15) @(negedge clk); // after E+18: inside data bit 3
      checks += 2;
      if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_pre: got %b, required 1", busy); end
      if (tx !== 1'b1)   begin errors++; $display("FAIL rm_tx_pre: got %b, required 1", tx); end
      #2 rst = 1'b0;
      #1;
      checks += 4;
      if (tx !== 1'b1)         begin errors++; $display("FAIL rm_tx_async: got %b, required 1", tx); end
      if (busy !== 1'b0)       begin errors++; $display("FAIL rm_busy_async: got %b, required 0", busy); end
      if (fifo_count !== 4'd0) begin errors++; $display("FAIL rm_count_async: got %0d, required 0", fifo_count); end
      if (tx_ready !== 1'b1)   begin errors++; $display("FAIL rm_ready_async: got %b, required 1", tx_ready); end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checks++;
         if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rm_idle cycle %0d: tx=%b busy=%b, required tx=1 busy=0", i, tx, busy);
         end
      end
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      @(negedge clk);            // after E'
      tx_valid = 1'b0;
      @(negedge clk);            // after E'+1
      checks += 2;
      if (busy !== 1'b1) begin errors++; $display("FAIL rm_new_busy: got %b, required 1", busy); end
      if (tx !== 1'b0)   begin errors++; $display("FAIL rm_new_start: got %b, required 0", tx); end
      rx_byte(b);
      checks++;
      if (b !== 8'h3C) begin errors++; $display("FAIL rm_new_byte: got %h, required 3c", b); end
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      rst      = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      test_reset();
      test_single();
      repeat (5) @(negedge clk);
      test_back_to_back();
      repeat (5) @(negedge clk);
      test_overflow();
      test_full_pop();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
